// File: rtl/calc_pkg.sv
// Shared definitions for the calculator ALU arithmetic blocks.
// Holds the divider width default, its FSM encoding and the ALU opcodes for MUL/DIV.
package calc_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } div_state_t;

    localparam logic [3:0] ALU_OP_MUL = 4'h6;
    localparam logic [3:0] ALU_OP_DIV = 4'h7;

endpackage

// File: rtl/div_complement_to_2.sv
// Conditional two's-complement negate on a W+1-bit value.
// Used for operand magnitudes on the way in and for the sign fix on the way out.
module div_complement_to_2 #(
    parameter int W = 4
) (
    input  logic [W:0] i_val,
    input  logic       i_neg,
    output logic [W:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{W{1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/divide_block.sv
// Sequential signed restoring divider, one quotient bit per clock on magnitudes.
// state | meaning: IDLE wait start | PREP magnitudes/flags | ITER W bit steps | FIX sign fix, done
module divide_block
    import calc_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         start,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CNT_W = $clog2(W);
    localparam int IDX_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_t r_state;
    div_state_t w_state_next;

    logic [W-1:0]     r_a_op;
    logic [W-1:0]     r_b_op;
    logic [W:0]       r_a_mag;
    logic [W:0]       r_b_mag;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [W-1:0]     r_quotient;
    logic [W-1:0]     r_remainder;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_prep;
    logic             w_iter;
    logic             w_fix;
    logic             w_last;
    logic [IDX_W-1:0] w_idx;
    logic [W:0]       w_shift;
    logic [W:0]       w_diff;
    logic             w_ge;
    logic [W:0]       w_na_in;
    logic             w_na_neg;
    logic [W:0]       w_na_out;
    logic [W:0]       w_nb_in;
    logic             w_nb_neg;
    logic [W:0]       w_nb_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_PREP;
            ST_PREP: w_state_next = ST_ITER;
            ST_ITER: if (w_last) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A start during the done cycle is refused so the earliest restart is one cycle later.
    always_comb begin
        w_accept = 1'b0;
        w_prep   = 1'b0;
        w_iter   = 1'b0;
        w_fix    = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = start & ~r_done;
            ST_PREP: w_prep   = 1'b1;
            ST_ITER: w_iter   = 1'b1;
            ST_FIX:  w_fix    = 1'b1;
            default: ;
        endcase
    end

    assign w_last  = (r_cnt == '0);
    assign w_idx   = IDX_W'(r_cnt);
    assign w_shift = {r_rem[W-1:0], r_a_mag[w_idx]};
    assign w_ge    = (w_shift >= r_b_mag);
    assign w_diff  = w_shift - r_b_mag;

    assign w_na_in  = w_prep ? {r_a_op[W-1], r_a_op} : {1'b0, r_q};
    assign w_na_neg = w_prep ? r_a_op[W-1] : r_q_neg;
    assign w_nb_in  = w_prep ? {r_b_op[W-1], r_b_op} : r_rem;
    assign w_nb_neg = w_prep ? r_b_op[W-1] : r_r_neg;

    div_complement_to_2 #(.W(W)) u_neg_a (
        .i_val (w_na_in),
        .i_neg (w_na_neg),
        .o_val (w_na_out)
    );

    div_complement_to_2 #(.W(W)) u_neg_b (
        .i_val (w_nb_in),
        .i_neg (w_nb_neg),
        .o_val (w_nb_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_op      <= '0;
            r_b_op      <= '0;
            r_a_mag     <= '0;
            r_b_mag     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_a_op <= dividend;
                r_b_op <= divisor;
                r_dbz  <= 1'b0;
                r_ovf  <= 1'b0;
                r_busy <= 1'b1;
            end
            if (w_prep) begin
                r_a_mag <= w_na_out;
                r_b_mag <= w_nb_out;
                r_q_neg <= r_a_op[W-1] ^ r_b_op[W-1];
                r_r_neg <= r_a_op[W-1];
                r_dbz   <= (r_b_op == '0);
                r_ovf   <= (r_a_op == MOST_NEG) && (r_b_op == '1);
                r_rem   <= '0;
                r_q     <= '0;
                r_cnt   <= CNT_LAST;
            end
            if (w_iter) begin
                r_rem      <= w_ge ? w_diff : w_shift;
                r_q[r_cnt] <= w_ge;
                if (!w_last) r_cnt <= r_cnt - CNT_W'(1);
            end
            // Special cases still take the full iteration time; only the result is overridden.
            if (w_fix) begin
                r_busy <= 1'b0;
                if (r_dbz) begin
                    r_quotient  <= '1;
                    r_remainder <= r_a_op;
                end else if (r_ovf) begin
                    r_quotient  <= MOST_NEG;
                    r_remainder <= '0;
                end else begin
                    r_quotient  <= w_na_out[W-1:0];
                    r_remainder <= w_nb_out[W-1:0];
                end
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
